// File: rtl/regfile_pkg.sv
// Shared constants and types for the RegisterFile writeback arbiter.
package regfile_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: req[0]/grant[0] is the ALU, req[1]/grant[1] the load path.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_t r_last_grant;

  // On a tie, the requester that was not served most recently wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (r_last_grant == REQ_MEM) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= REQ_MEM;
    end else if (grant[0]) begin
      r_last_grant <= REQ_ALU;
    end else if (grant[1]) begin
      r_last_grant <= REQ_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RegisterFile write port between ALU and load writeback and tracks pending rd.
// Optional macro WB_BYPASS_EN adds writeback-cycle forwarding ports for the decode sources.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   chk_rs1,
  input  logic [AW-1:0]   chk_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_reg_write,
  output logic [AW-1:0]   rf_write_reg,
  output logic [XLEN-1:0] rf_write_data,
  output logic [NREG-1:0] pending
`ifdef WB_BYPASS_EN
  ,
  output logic            rs1_fwd_valid,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic            rs2_fwd_valid,
  output logic [XLEN-1:0] rs2_fwd_data
`endif
);

  logic [1:0]      w_grant;
  logic            w_xfer;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_data;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_pend_next;

  logic            r_reg_write;
  logic [AW-1:0]   r_write_reg;
  logic [XLEN-1:0] r_write_data;
  logic [NREG-1:0] r_pending;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({mem_valid, alu_valid}),
    .grant (w_grant)
  );

  assign alu_ready = w_grant[0];
  assign mem_ready = w_grant[1];
  assign w_xfer    = |w_grant;
  assign w_rd      = w_grant[1] ? mem_rd   : alu_rd;
  assign w_data    = w_grant[1] ? mem_data : alu_data;

  // A transfer to x0 completes the handshake but never raises the write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_xfer && (w_rd != '0);
      if (w_xfer) begin
        r_write_reg  <= w_rd;
        r_write_data <= w_data;
      end
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && (issue_rd != '0)) w_set[issue_rd] = 1'b1;
    if (r_reg_write) w_clr[r_write_reg] = 1'b1;
    // Set is applied after clear: a newly issued writer outranks the committing one.
    w_pend_next = (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= {w_pend_next[NREG-1:1], 1'b0};
    end
  end

  assign rf_reg_write  = r_reg_write;
  assign rf_write_reg  = r_write_reg;
  assign rf_write_data = r_write_data;
  assign pending       = r_pending;

`ifdef WB_BYPASS_EN
  assign rs1_fwd_valid = r_reg_write && (r_write_reg == chk_rs1) && (chk_rs1 != '0);
  assign rs2_fwd_valid = r_reg_write && (r_write_reg == chk_rs2) && (chk_rs2 != '0);
  assign rs1_fwd_data  = r_write_data;
  assign rs2_fwd_data  = r_write_data;
  assign rs1_busy      = r_pending[chk_rs1] && !rs1_fwd_valid;
  assign rs2_busy      = r_pending[chk_rs2] && !rs2_fwd_valid;
`else
  // Busy stays up through the commit cycle since the RegisterFile read is still stale.
  assign rs1_busy = r_pending[chk_rs1];
  assign rs2_busy = r_pending[chk_rs2];
`endif

endmodule
